// File: rtl/window3x3_linebuf.sv
// ============================================================================
// Module   : window3x3_linebuf
// Brief    : Two-line buffer plus 3x3 register window over a raster pixel stream
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module window3x3_linebuf #(
    parameter int width = 12,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             pix_valid,
    input  logic [width-1:0] pix_in,
    output logic [width-1:0] win0,
    output logic [width-1:0] win1,
    output logic [width-1:0] win2,
    output logic [width-1:0] win3,
    output logic [width-1:0] win4,
    output logic [width-1:0] win5,
    output logic [width-1:0] win6,
    output logic [width-1:0] win7,
    output logic [width-1:0] win8,
    output logic             win_valid
);

    localparam int                c_col_w    = $clog2(IMG_W);
    localparam int                c_row_w    = $clog2(IMG_H);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);

    logic [c_col_w-1:0] r_col, w_col, w_col_nxt, r_s1_col;
    logic [c_row_w-1:0] r_row, w_row, w_row_nxt, r_s1_row;
    logic               r_s1_valid;
    logic [width-1:0]   r_s1_pix;
    logic [width-1:0]   r_lba_q, r_lbb_q;
    logic [width-1:0]   r_lb_a [IMG_W];
    logic [width-1:0]   r_lb_b [IMG_W];
    logic [width-1:0]   r_win  [9];
    logic               r_win_valid;

    // sof forces the current pixel to (0,0) regardless of counter state
    always_comb begin
        w_col     = sof ? '0 : r_col;
        w_row     = sof ? '0 : r_row;
        w_col_nxt = w_col + c_col_w'(1);
        w_row_nxt = w_row;
        if (w_col == c_col_last) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == c_row_last) ? '0 : w_row + c_row_w'(1);
        end
    end

    // Read-first line buffers: lb_a cascades into lb_b, no reset on storage
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_lba_q        <= r_lb_a[w_col];
            r_lbb_q        <= r_lb_b[w_col];
            r_lb_a[w_col]  <= pix_in;
            r_lb_b[w_col]  <= r_lb_a[w_col];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_pix    <= '0;
            r_s1_col    <= '0;
            r_s1_row    <= '0;
            r_win_valid <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else if (pix_valid) begin
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_s1_valid <= 1'b1;
            r_s1_pix   <= pix_in;
            r_s1_col   <= w_col;
            r_s1_row   <= w_row;
            if (r_s1_valid) begin
                r_win[0]    <= r_win[1];
                r_win[1]    <= r_win[2];
                r_win[2]    <= r_lbb_q;
                r_win[3]    <= r_win[4];
                r_win[4]    <= r_win[5];
                r_win[5]    <= r_lba_q;
                r_win[6]    <= r_win[7];
                r_win[7]    <= r_win[8];
                r_win[8]    <= r_s1_pix;
                r_win_valid <= (r_s1_row >= c_row_w'(2)) && (r_s1_col >= c_col_w'(2));
            end else begin
                r_win_valid <= 1'b0;
            end
        end else begin
            r_win_valid <= 1'b0;
        end
    end

    assign win0      = r_win[0];
    assign win1      = r_win[1];
    assign win2      = r_win[2];
    assign win3      = r_win[3];
    assign win4      = r_win[4];
    assign win5      = r_win[5];
    assign win6      = r_win[6];
    assign win7      = r_win[7];
    assign win8      = r_win[8];
    assign win_valid = r_win_valid;

endmodule

`default_nettype wire

// File: tb/tb_window3x3_linebuf.sv
// ============================================================================
// Module   : tb_window3x3_linebuf
// Brief    : Directed self-checking bench for window3x3_linebuf (4x4 image)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window3x3_linebuf;

    localparam int c_w  = 12;
    localparam int c_iw = 4;
    localparam int c_ih = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sof = 1'b0;
    logic           pix_valid = 1'b0;
    logic [c_w-1:0] pix_in = '0;
    logic [c_w-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
    logic [c_w-1:0] wv [9];
    logic           win_valid;

    int total = 0;
    int bad   = 0;
    int nstrobe = 0;
    bit pend_has = 0;
    int pend_r = 0;
    int pend_c = 0;

    always #5 clk = ~clk;

    assign wv[0] = w0; assign wv[1] = w1; assign wv[2] = w2;
    assign wv[3] = w3; assign wv[4] = w4; assign wv[5] = w5;
    assign wv[6] = w6; assign wv[7] = w7; assign wv[8] = w8;

    window3x3_linebuf #(.width(c_w), .IMG_W(c_iw), .IMG_H(c_ih)) dut (
        .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
        .win0(w0), .win1(w1), .win2(w2), .win3(w3), .win4(w4),
        .win5(w5), .win6(w6), .win7(w7), .win8(w8), .win_valid(win_valid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {31'b0, win_valid}, 32'd0);
        for (int k = 0; k < 9; k++) chk($sformatf("%s_win%0d", tag, k), {20'b0, wv[k]}, 32'd0);
    endtask

    // Accept pixel at frame position (r,c); its window appears one accept later
    task automatic acc(input logic s, input int r, input int c);
        logic exp_v;
        sof = s; pix_valid = 1'b1; pix_in = c_w'(r * 16 + c);
        @(posedge clk); #1;
        exp_v = pend_has && pend_r >= 2 && pend_c >= 2;
        chk($sformatf("valid_after_%0d_%0d", r, c), {31'b0, win_valid}, {31'b0, exp_v});
        if (win_valid) nstrobe++;
        if (exp_v) begin
            for (int k = 0; k < 9; k++)
                chk($sformatf("win%0d_at_%0d_%0d", k, pend_r, pend_c), {20'b0, wv[k]},
                    32'((pend_r - 2 + k / 3) * 16 + (pend_c - 2 + k % 3)));
        end
        pend_has = 1; pend_r = r; pend_c = c;
        sof = 1'b0;
    endtask

    task automatic idle(input logic s);
        logic [c_w-1:0] h4, h8;
        h4 = w4; h8 = w8;
        sof = s; pix_valid = 1'b0; pix_in = 12'hfff;
        @(posedge clk); #1;
        chk("gap_valid", {31'b0, win_valid}, 32'd0);
        chk("gap_hold_win4", {20'b0, w4}, {20'b0, h4});
        chk("gap_hold_win8", {20'b0, w8}, {20'b0, h8});
        sof = 1'b0;
    endtask

    task automatic frame(input bit s, input bit gaps);
        for (int r = 0; r < c_ih; r++) begin
            for (int c = 0; c < c_iw; c++) begin
                acc(s && r == 0 && c == 0, r, c);
                if (gaps) begin
                    idle(1'b0);
                    if (r == 2 && c == 1) repeat (4) idle(1'b1);
                end
            end
        end
    endtask

    initial begin
        // reset held while pixels stream in
        #2 rst = 1'b0;
        #1 chk_zero("reset");
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1; sof = (i == 0); pix_in = c_w'(i + 1);
            @(posedge clk); #1;
            chk_zero("rst_hold");
        end
        pix_valid = 1'b0; sof = 1'b0;
        rst = 1'b1;
        pend_has = 0;

        // continuous frame, flushed by the next frame's first pixel
        nstrobe = 0;
        frame(1'b1, 1'b0);
        acc(1'b0, 0, 0);
        chk("strobes_cont", nstrobe, 32'd4);

        // alternating gaps plus a long gap with stray sof
        nstrobe = 0;
        frame(1'b1, 1'b1);
        acc(1'b0, 0, 0);
        chk("strobes_gaps", nstrobe, 32'd4);

        // two back-to-back frames, only the first carries sof
        nstrobe = 0;
        frame(1'b1, 1'b0);
        frame(1'b0, 1'b0);
        acc(1'b0, 0, 0);
        chk("strobes_2frames", nstrobe, 32'd8);

        // sof arriving at position (1,2) restarts the frame there
        for (int i = 0; i < 6; i++) acc(i == 0, i / 4, i % 4);
        nstrobe = 0;
        frame(1'b1, 1'b0);
        acc(1'b0, 0, 0);
        chk("strobes_resync", nstrobe, 32'd4);

        // reset pulse right after pixel 0x21
        nstrobe = 0;
        for (int i = 0; i < 10; i++) acc(i == 0, i / 4, i % 4);
        rst = 1'b0;
        #1 chk_zero("mid_reset");
        pix_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        pend_has = 0;
        acc(1'b0, 0, 0);
        chk("no_strobe_after_reset", nstrobe, 32'd0);
        frame(1'b1, 1'b0);
        acc(1'b0, 0, 0);
        chk("strobes_after_reset", nstrobe, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/window3x3_linebuf.md
Name: window3x3_linebuf

Overview:
- Builds the 3x3 pixel neighbourhood for the median-filter compare stage from the raster-ordered camera pixel stream.
- Holds two full image lines in line buffers plus a 3x3 register window.
- Presents nine window pixels and a one-cycle valid strobe each time a new full-interior window is formed.
- win_valid drives the compare stage's enable input; win0..win8 drive its din0..din8.

Parameters:
- width, 12, pixel width in bits (RGB444).
- IMG_W, 640, pixels per line; ≥3.
- IMG_H, 480, lines per frame; ≥3.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- sof  input  1  start of frame; qualifies the pixel on the same cycle as pixel (0,0)
- pix_valid  input  1  pix_in valid this cycle; accepted every cycle it is high, no backpressure
- pix_in  input  width  raster-order pixel
- win0..win8  output  width each  window pixels in raster order:
  - win0 = (r-2,c-2), win1 = (r-2,c-1), win2 = (r-2,c)
  - win3..win5 = row r-1
  - win6..win8 = row r; win8 is the newest pixel
  - centre is win4 = (r-1,c-1)
- win_valid  output  1  one-cycle strobe; win0..win8 valid while high

Behaviour:
- Reset (rst low, asynchronous):
  - col/row counters = 0, window registers = 0, win0..win8 = 0, win_valid = 0, pipeline valid = 0.
  - Line-buffer RAM contents are not cleared; rows 0 and 1 of each frame refill them before use.
- Accept: a pixel is accepted on any rising edge with pix_valid = 1. With pix_valid = 0, counters, window and outputs hold, and win_valid = 0.
- Position:
  - sof & pix_valid: pixel is (0,0) regardless of counter state (resync); counters then go to col = 1, row = 0.
  - Otherwise col increments; at col = IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_W-1, IMG_H-1) both wrap to 0.
  - sof without pix_valid is ignored.
- Line buffers: lb_a holds row r-1, lb_b holds row r-2, both IMG_W × width, synchronous read, read-first.
  - Edge N (accept at column c): read lb_a[c] and lb_b[c]; write lb_a[c] <= pix_in and lb_b[c] <= old lb_a[c].
  - Register pix_in, col, row and an accept flag into stage 1.
- Edge N+1 (stage 1 valid): shift window columns left and load the new right column = {lb_b data, lb_a data, registered pixel}.
  - win_valid <= 1 iff stage-1 row ≥ 2 and col ≥ 2; otherwise win_valid <= 0.
  - win0..win8 update on every stage-1 shift; they are meaningful only when win_valid = 1.
- Latency: pixel accepted at edge N ⇒ win_valid high for the cycle after edge N+1 (2 cycles).
- Throughput: back-to-back pixels give back-to-back strobes.
- Border windows (row < 2 or col < 2) are never flagged, including the columns 0/1 windows that straddle the previous line's tail. There are exactly (IMG_W-2)·(IMG_H-2) strobes per frame.
- Pixel gaps: a stalled pipeline stage is held; data is never dropped or duplicated.
- Read and write at the same address in the same cycle return the old data.
- Reset mid-frame: the pipeline is flushed, no strobe follows, and the next accepted pixel is (0,0) even without sof.

Test Plan:
(Params IMG_W = 4, IMG_H = 4; pixel value = row·16 + col.)
- Continuous frame with sof on the first pixel → exactly 4 strobes.
  - First strobe 2 cycles after pixel 0x22 is accepted; win0..win8 = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22.
  - Last strobe has win4 = 0x22, win8 = 0x33.
- Same frame with pix_valid low on alternate cycles, plus one 5-cycle gap mid-row 2 → same 4 windows and values, each strobe 2 accepted-cycles after its pixel, win_valid never high during gaps.
- Two frames back-to-back without a second sof → frame 2 gives 4 strobes identical to frame 1; no strobe for frame-2 rows 0–1 or columns 0–1.
- sof asserted at frame position (1,2) → that pixel is treated as (0,0); the first strobe comes only after 2 more full rows + 3 pixels.
- rst pulsed low for 1 cycle after pixel 0x21 → win_valid = 0 and win0..win8 = 0 immediately; no strobe for 0x22. A fresh frame afterwards gives the first test's results.
- Reset held during pixel activity → no strobe, outputs stay 0.
